nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter FCW_W, default 16, giving the frequency control word width, which matches the NCO phase accumulator width N.
REQ-002 The block SHALL have parameter DWELL_W, default 16, giving the dwell counter width.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock, which is the NCO clock domain.
REQ-004 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports cfg_start_fcw, cfg_stop_fcw and cfg_step, each input, FCW_W bits: the sweep start word, stop word and increment.
REQ-006 The block SHALL have port cfg_dwell, input, DWELL_W bits: the number of cycles each word is held.
REQ-007 The block SHALL have port cfg_mode, input, 1 bit: 0 selects a single sweep, 1 selects a continuous (repeating) sweep.
REQ-008 The block SHALL have port start, input, 1 bit: a one-cycle request that begins a sweep.
REQ-009 The block SHALL have port abort, input, 1 bit: stops any sweep in progress.
REQ-010 The block SHALL have port fcw_out, output, FCW_W bits: the word driven to the NCO phi_inc input.
REQ-011 The block SHALL have port fcw_update, output, 1 bit: a one-cycle pulse on every change of fcw_out.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a sweep is active.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a single sweep completes.

Function
REQ-014 The FSM SHALL have states IDLE, DWELL, STEP and DONE.
REQ-015 In IDLE, when start=1 and abort=0, the block SHALL latch all cfg_* inputs, load fcw_out with cfg_start_fcw, pulse fcw_update, set busy and enter DWELL, all visible on the next cycle.
REQ-016 The block SHALL ignore start while busy=1, and cfg_* changes during a sweep SHALL have no effect.
REQ-017 The block SHALL hold each word for exactly D = max(cfg_dwell, 1) cycles, measured from its fcw_update pulse to the next fcw_update pulse or the done pulse.
REQ-018 In STEP, the block SHALL compute next = fcw_out + step at FCW_W+1 bits.
- If next <= stop, with no wrap: fcw_out <= next[FCW_W-1:0], fcw_update pulses, and the FSM returns to DWELL.
- Otherwise, in single mode the FSM goes to DONE; in continuous mode fcw_out <= start, fcw_update pulses, and the FSM returns to DWELL.
REQ-019 STEP SHALL consume no extra cycle, so the step decision is registered in the last dwell cycle.
REQ-020 DONE SHALL last one cycle: done=1 and busy=0 in that cycle, then the FSM returns to IDLE.
REQ-021 After done, fcw_out SHALL hold the last word until the next start.
REQ-022 Boundary cases SHALL behave as follows:
- step=0: the start word is held for one dwell, then the sweep ends (single) or holds the start word indefinitely (continuous).
- start > stop: the start word is held for one dwell, then the sweep ends or reloads.
- start = stop: identical to the start > stop case.
REQ-023 When abort=1 in any state, the FSM SHALL go to IDLE next cycle with busy=0, done=0 and fcw_out held; abort SHALL win over a simultaneous start.
REQ-024 fcw_update SHALL NOT pulse on abort.

Reset
REQ-025 While sys_rst_n=0, the block SHALL force the FSM to IDLE and fcw_out=0, fcw_update=0, busy=0, done=0, with the dwell counter and latched config at 0.
REQ-026 Reset asserted mid-sweep SHALL abandon the sweep without a done pulse; the first start after release SHALL behave per REQ-015.

Structure
REQ-027 Package nco_ctrl_pkg SHALL hold the FSM state enum, the MODE_SINGLE and MODE_CONT constants, and the default FCW_W and DWELL_W values.
REQ-028 The block SHALL instantiate one sub-module, nco_dwell_timer: a loadable down-counter with a load input and an expire output that asserts in the last cycle of D.
REQ-029 The step compare SHALL be done in nco_sweep_ctrl, not in the timer.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Single sweep with start=100, stop=400, step=100, dwell=4, start pulse at cycle t: fcw_out = 100@t+1, 200@t+5, 300@t+9, 400@t+13; done=1 and busy=0 @t+17; fcw_out stays 400.
- Continuous mode, same config: after 400, fcw_out returns to 100 @t+17 with an fcw_update pulse; done is never asserted.
- Wrap: FCW_W=16, start=65000, stop=65535, step=600, dwell=0: fcw_out=65000 for 1 cycle, then done, with no wrapped word output.
- Abort asserted @t+6 during the single sweep: busy=0 @t+7, fcw_out=200 held, no done pulse; a start issued together with abort in IDLE is ignored.
- sys_rst_n low @t+10 mid-sweep: all outputs 0 asynchronously; a start after release gives fcw_out = cfg_start_fcw one cycle later.
- step=0, single mode: one dwell at the start word, then done; a start while busy is ignored.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO frequency-sweep controller: FSM states,
// sweep mode encodings and default widths.
package nco_ctrl_pkg;

  localparam int unsigned FCW_W_DEF   = 16;
  localparam int unsigned DWELL_W_DEF = 16;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

  // STEP is a decision point evaluated in the last dwell cycle; the FSM never rests there.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter: loaded with D-1, expire is high in the last cycle of the dwell.
module nco_dwell_timer
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep controller: steps the NCO frequency control word from start to stop,
// holding each word for a programmable dwell, in single-shot or repeating mode.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned FCW_W   = FCW_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [FCW_W-1:0]   cfg_start_fcw,
  input  logic [FCW_W-1:0]   cfg_stop_fcw,
  input  logic [FCW_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_mode,
  input  logic               start,
  input  logic               abort,
  output logic [FCW_W-1:0]   fcw_out,
  output logic               fcw_update,
  output logic               busy,
  output logic               done
);

  sweep_state_e       state_q;
  logic [FCW_W-1:0]   fcw_q, start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               mode_q, upd_q, busy_q, done_q;

  logic [FCW_W:0]     fcw_d;
  logic               adv_ok, accept, reload, tmr_load, expire;
  logic [DWELL_W-1:0] dwell_m1, tmr_val;

  // One extra bit so a sum past the top of the word range never compares as in-range.
  assign fcw_d    = {1'b0, fcw_q} + {1'b0, step_q};
  assign adv_ok   = (step_q != '0) && (fcw_d <= {1'b0, stop_q});

  assign dwell_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
  assign accept   = (state_q == ST_IDLE) && start && !abort;
  assign reload   = (state_q == ST_DWELL) && expire && !abort &&
                    (adv_ok || (mode_q == MODE_CONT));
  assign tmr_load = accept || reload;
  assign tmr_val  = accept ? dwell_m1 : dwell_q;

  nco_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      fcw_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_SINGLE;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      upd_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              start_q <= cfg_start_fcw;
              stop_q  <= cfg_stop_fcw;
              step_q  <= cfg_step;
              dwell_q <= dwell_m1;
              mode_q  <= cfg_mode;
              fcw_q   <= cfg_start_fcw;
              upd_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_DWELL;
            end
          end
          ST_DWELL: begin
            if (expire) begin
              if (adv_ok) begin
                fcw_q <= fcw_d[FCW_W-1:0];
                upd_q <= 1'b1;
              end else if (mode_q == MODE_CONT) begin
                // Reloading the word already on the output is not a change, so no pulse.
                fcw_q <= start_q;
                upd_q <= (fcw_q != start_q);
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign fcw_out    = fcw_q;
  assign fcw_update = upd_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed sweep scenarios plus randomized
// configurations compared cycle by cycle against a word-list reference model.
module tb_nco_sweep_ctrl;
  import nco_ctrl_pkg::*;

  localparam int unsigned FW = 16;
  localparam int unsigned DW = 16;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic [FW-1:0] cfg_start_fcw = '0, cfg_stop_fcw = '0, cfg_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          cfg_mode  = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [FW-1:0] fcw_out;
  logic          fcw_update, busy, done;

  nco_sweep_ctrl #(
    .FCW_W   (FW),
    .DWELL_W (DW)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .cfg_start_fcw (cfg_start_fcw),
    .cfg_stop_fcw  (cfg_stop_fcw),
    .cfg_step      (cfg_step),
    .cfg_dwell     (cfg_dwell),
    .cfg_mode      (cfg_mode),
    .start         (start),
    .abort         (abort),
    .fcw_out       (fcw_out),
    .fcw_update    (fcw_update),
    .busy          (busy),
    .done          (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [FW-1:0] fcw;
    logic          upd;
    logic          busy;
    logic          done;
  } obs_t;

  int errors = 0;
  int checks = 0;

  // Reference model: the list of words a sweep visits, the dwell length and the mode.
  logic [FW-1:0] m_words[$];
  int            m_d;
  bit            m_cont;

  function automatic obs_t observe();
    obs_t o;
    o.fcw  = fcw_out;
    o.upd  = fcw_update;
    o.busy = busy;
    o.done = done;
    return o;
  endfunction

  function automatic void build_model(int s, int p, int st, int dw, bit cont);
    int w;
    m_words.delete();
    w = s;
    m_words.push_back(FW'(w));
    for (int i = 0; i < 64; i++) begin
      if (st == 0 || w + st > p) break;
      w = w + st;
      m_words.push_back(FW'(w));
    end
    m_d    = (dw == 0) ? 1 : dw;
    m_cont = cont;
  endfunction

  // Expected outputs k cycles after the start request was sampled.
  function automatic obs_t model_at(int k);
    obs_t r;
    int n, tot, idx, prv;
    n   = m_words.size();
    tot = n * m_d;
    r   = '0;
    if (!m_cont && k > tot) begin
      r.fcw  = m_words[n-1];
      r.done = (k == tot + 1);
      return r;
    end
    idx    = ((k - 1) / m_d) % n;
    prv    = (idx + n - 1) % n;
    r.fcw  = m_words[idx];
    r.busy = 1'b1;
    r.upd  = ((k - 1) % m_d == 0) && (k == 1 || m_words[idx] != m_words[prv]);
    return r;
  endfunction

  // Starts a sweep and compares ncyc cycles against the model; optionally disturbs
  // the config inputs and re-requests start while the sweep is busy.
  task automatic run_sweep(input int s, input int p, input int st, input int dw,
                           input bit cont, input int ncyc, input bit disturb,
                           input string name, output obs_t last);
    obs_t obs, exp;
    bit   dist_on;
    dist_on       = 1'b0;
    cfg_start_fcw = FW'(s);
    cfg_stop_fcw  = FW'(p);
    cfg_step      = FW'(st);
    cfg_dwell     = DW'(dw);
    cfg_mode      = cont;
    build_model(s, p, st, dw, cont);
    start = 1'b1;
    last  = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge sys_clk);
      if (k == 1) start = 1'b0;
      if (k == 3 && dist_on) start = 1'b0;
      obs = observe();
      exp = model_at(k);
      last = exp;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s k=%0d: got fcw=%0d upd=%b busy=%b done=%b, want fcw=%0d upd=%b busy=%b done=%b",
                 name, k, obs.fcw, obs.upd, obs.busy, obs.done, exp.fcw, exp.upd, exp.busy, exp.done);
      end
      if (k == 2 && disturb && exp.busy) begin
        dist_on       = 1'b1;
        cfg_start_fcw = FW'($urandom);
        cfg_stop_fcw  = FW'($urandom);
        cfg_step      = FW'($urandom);
        cfg_dwell     = DW'($urandom_range(0, 7));
        cfg_mode      = ~cfg_mode;
        start         = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    obs_t obs;
    #1 sys_rst_n = 1'b0;
    #2;
    obs = observe();
    checks++;
    if (obs !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset: got fcw=%0d upd=%b busy=%b done=%b, want all zero",
               obs.fcw, obs.upd, obs.busy, obs.done);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_single();
    obs_t last;
    run_sweep(100, 400, 100, 4, 1'b0, 20, 1'b0, "single", last);
  endtask

  task automatic test_continuous();
    obs_t last, obs;
    run_sweep(100, 400, 100, 4, 1'b1, 34, 1'b0, "cont", last);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    obs = observe();
    checks++;
    if (obs !== {last.fcw, 3'b000}) begin
      errors++;
      $display("FAIL cont_abort: got fcw=%0d upd=%b busy=%b done=%b, want fcw=%0d idle",
               obs.fcw, obs.upd, obs.busy, obs.done, last.fcw);
    end
  endtask

  task automatic test_wrap();
    obs_t last;
    run_sweep(65000, 65535, 600, 0, 1'b0, 4, 1'b0, "wrap", last);
  endtask

  task automatic test_abort();
    obs_t last, obs;
    run_sweep(100, 400, 100, 4, 1'b0, 6, 1'b0, "abort_pre", last);
    abort = 1'b1;
    @(negedge sys_clk);
    start = 1'b1;
    obs = observe();
    checks++;
    if (obs !== {FW'(200), 3'b000}) begin
      errors++;
      $display("FAIL abort: got fcw=%0d upd=%b busy=%b done=%b, want fcw=200 idle",
               obs.fcw, obs.upd, obs.busy, obs.done);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      start = 1'b0;
      abort = 1'b0;
      obs = observe();
      checks++;
      if (obs !== {FW'(200), 3'b000}) begin
        errors++;
        $display("FAIL abort_hold i=%0d: got fcw=%0d upd=%b busy=%b done=%b, want fcw=200 idle",
                 i, obs.fcw, obs.upd, obs.busy, obs.done);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t last, obs;
    run_sweep(100, 400, 100, 4, 1'b0, 10, 1'b0, "rstmid_pre", last);
    sys_rst_n = 1'b0;
    #1;
    obs = observe();
    checks++;
    if (obs !== obs_t'('0)) begin
      errors++;
      $display("FAIL rst_async: got fcw=%0d upd=%b busy=%b done=%b, want all zero",
               obs.fcw, obs.upd, obs.busy, obs.done);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    run_sweep(300, 900, 200, 2, 1'b0, 12, 1'b0, "rstmid_post", last);
  endtask

  task automatic test_step_zero();
    obs_t last;
    run_sweep(1234, 5000, 0, 3, 1'b0, 7, 1'b1, "step0", last);
  endtask

  task automatic test_back_to_back();
    obs_t last;
    run_sweep(10, 30, 10, 1, 1'b0, 5, 1'b0, "b2b_a", last);
    run_sweep(500, 520, 5, 2, 1'b0, 12, 1'b0, "b2b_b", last);
  endtask

  task automatic test_random();
    obs_t last, obs;
    int s, p, st, dw, n, sel, ncyc;
    bit cont;
    for (int it = 0; it < 14; it++) begin
      s    = $urandom_range(0, 60000);
      st   = $urandom_range(1, 3000);
      n    = $urandom_range(1, 6);
      p    = s + (n - 1) * st + $urandom_range(0, st - 1);
      if (p > 65535) p = 65535;
      dw   = $urandom_range(0, 5);
      cont = $urandom_range(0, 1) == 1;
      sel  = $urandom_range(0, 5);
      if (sel == 0) st = 0;
      if (sel == 1 && s > 0) p = $urandom_range(0, s - 1);
      if (sel == 2) p = s;
      build_model(s, p, st, dw, cont);
      if (m_words.size() < 2) cont = 1'b0;
      ncyc = cont ? 2 * m_words.size() * m_d + 3 : m_words.size() * m_d + 2;
      run_sweep(s, p, st, dw, cont, ncyc, 1'b1, "random", last);
      if (cont) begin
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        obs = observe();
        checks++;
        if (obs !== {last.fcw, 3'b000}) begin
          errors++;
          $display("FAIL random_abort it=%0d: got fcw=%0d upd=%b busy=%b done=%b, want fcw=%0d idle",
                   it, obs.fcw, obs.upd, obs.busy, obs.done, last.fcw);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_step_zero();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
